// File: rtl/otter_wb_arbiter.sv
// Register-file writeback arbiter for the OTTER core.
// Merges two writeback sources into a single register-file write port:
//   A: the in-order pipeline. It has no back-pressure and always has priority.
//   B: long-latency units. Their writes are buffered in a small FIFO.
// A 31-entry scoreboard tracks registers that still have a long-latency write
// pending, so that decode can stall on them.
// Optional feature: define OTTER_WB_BYPASS_EN to let a B write reach the
// output in the same cycle it arrives. This happens only when the FIFO is
// empty and A is idle.
module otter_wb_arbiter #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_a_valid,
  input  logic [4:0]  i_a_addr,
  input  logic [31:0] i_a_data,
  input  logic        i_b_valid,
  output logic        o_b_ready,
  input  logic [4:0]  i_b_addr,
  input  logic [31:0] i_b_data,
  input  logic        i_iss_valid,
  input  logic [4:0]  i_iss_addr,
  input  logic [4:0]  i_q_addr1,
  input  logic [4:0]  i_q_addr2,
  output logic        o_q_busy1,
  output logic        o_q_busy2,
  output logic        o_w_en,
  output logic [4:0]  o_w_addr,
  output logic [31:0] o_w_data
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  // FIFO storage: each entry is {addr, data}
  logic [36:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0]   sb_q, sb_d;
  logic [31:0]   sb_set, sb_clr;

  logic          w_en_d;
  logic [4:0]    w_addr_d;
  logic [31:0]   w_data_d;
  logic          w_en_q;
  logic [4:0]    w_addr_q;
  logic [31:0]   w_data_q;

  logic          empty, full;
  logic          sel_a, b_hs, byp, push, pop;
  logic [4:0]    head_addr;
  logic [31:0]   head_data;

  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_CNT);
  assign o_b_ready = !full;
  assign b_hs      = i_b_valid && o_b_ready;
  assign sel_a     = i_a_valid && (i_a_addr != 5'd0);
  assign head_addr = mem_q[rd_ptr_q][36:32];
  assign head_data = mem_q[rd_ptr_q][31:0];

`ifdef OTTER_WB_BYPASS_EN
  assign byp = b_hs && empty && !sel_a;
`else
  assign byp = 1'b0;
`endif
  assign push = b_hs && !byp;

  // Writeback selection: A first, then FIFO head, then bypassed B.
  // B entries retire their scoreboard bit when they are loaded.
  always_comb begin
    w_en_d   = 1'b0;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    sb_clr   = '0;
    pop      = 1'b0;
    if (sel_a) begin
      w_en_d   = 1'b1;
      w_addr_d = i_a_addr;
      w_data_d = i_a_data;
    end else if (!empty) begin
      pop      = 1'b1;
      w_en_d   = (head_addr != 5'd0);
      w_addr_d = head_addr;
      w_data_d = head_data;
      if (head_addr != 5'd0) sb_clr[head_addr] = 1'b1;
    end else if (byp) begin
      w_en_d   = (i_b_addr != 5'd0);
      w_addr_d = i_b_addr;
      w_data_d = i_b_data;
      if (i_b_addr != 5'd0) sb_clr[i_b_addr] = 1'b1;
    end
  end

  // FIFO pointer and occupancy next-state; push and pop may coincide
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Scoreboard next-state: a new issue wins over a retiring write to the same register
  always_comb begin
    sb_set = '0;
    if (i_iss_valid && (i_iss_addr != 5'd0)) sb_set[i_iss_addr] = 1'b1;
    sb_d    = (sb_q & ~sb_clr) | sb_set;
    sb_d[0] = 1'b0;
  end

  // Control, scoreboard and output registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sb_q     <= '0;
      w_en_q   <= 1'b0;
      w_addr_q <= 5'd0;
      w_data_q <= 32'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sb_q     <= sb_d;
      w_en_q   <= w_en_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
    end
  end

  // FIFO storage write; contents are only meaningful behind the pointers
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= {i_b_addr, i_b_data};
  end

  assign o_q_busy1 = sb_q[i_q_addr1];
  assign o_q_busy2 = sb_q[i_q_addr2];
  assign o_w_en    = w_en_q;
  assign o_w_addr  = w_addr_q;
  assign o_w_data  = w_data_q;

endmodule

// File: tb/tb_otter_wb_arbiter.sv
// Directed self-checking bench for otter_wb_arbiter (FIFO_DEPTH = 2).
module tb_otter_wb_arbiter;

  logic        clk, rst;
  logic        a_valid, b_valid, b_ready, iss_valid;
  logic [4:0]  a_addr, b_addr, iss_addr, q_addr1, q_addr2, w_addr;
  logic [31:0] a_data, b_data, w_data;
  logic        q_busy1, q_busy2, w_en;

  int checks = 0;
  int errors = 0;

  otter_wb_arbiter #(.FIFO_DEPTH(2)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_a_valid(a_valid), .i_a_addr(a_addr), .i_a_data(a_data),
    .i_b_valid(b_valid), .o_b_ready(b_ready), .i_b_addr(b_addr), .i_b_data(b_data),
    .i_iss_valid(iss_valid), .i_iss_addr(iss_addr),
    .i_q_addr1(q_addr1), .i_q_addr2(q_addr2),
    .o_q_busy1(q_busy1), .o_q_busy2(q_busy2),
    .o_w_en(w_en), .o_w_addr(w_addr), .o_w_data(w_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; a_valid = 0; a_addr = 0; a_data = 0;
    b_valid = 0; b_addr = 0; b_data = 0;
    iss_valid = 0; iss_addr = 0; q_addr1 = 0; q_addr2 = 0;
    #1;
    chk("rst_wen", {31'd0, w_en}, 32'd0);
    chk("rst_ready", {31'd0, b_ready}, 32'd1);
    tick();
    rst = 1'b0;

    // idle after reset
    q_addr1 = 5'd7; q_addr2 = 5'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_wen", {31'd0, w_en}, 32'd0);
      chk("idle_ready", {31'd0, b_ready}, 32'd1);
      chk("idle_busy1", {31'd0, q_busy1}, 32'd0);
      chk("idle_busy2", {31'd0, q_busy2}, 32'd0);
    end

    // source A basic write and x0 drop
    a_valid = 1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
    tick();
    chk("a_wen", {31'd0, w_en}, 32'd1);
    chk("a_addr", {27'd0, w_addr}, 32'd5);
    chk("a_data", w_data, 32'hDEADBEEF);
    a_addr = 5'd0; a_data = 32'h0BAD0BAD;
    tick();
    chk("a_x0_wen", {31'd0, w_en}, 32'd0);
    a_valid = 0;

    // scoreboard hold while A blocks B
    iss_valid = 1; iss_addr = 5'd7;
    tick();
    iss_valid = 0;
    chk("sb7_set", {31'd0, q_busy1}, 32'd1);
    a_valid = 1; a_addr = 5'd1; a_data = 32'h11;
    b_valid = 1; b_addr = 5'd7; b_data = 32'h12345678;
    tick();
    b_valid = 0;
    chk("sb7_a1_addr", {27'd0, w_addr}, 32'd1);
    chk("sb7_hold1", {31'd0, q_busy1}, 32'd1);
    tick();
    chk("sb7_hold2", {31'd0, q_busy1}, 32'd1);
    tick();
    chk("sb7_hold3", {31'd0, q_busy1}, 32'd1);
    a_valid = 0;
    tick();
    chk("sb7_b_wen", {31'd0, w_en}, 32'd1);
    chk("sb7_b_addr", {27'd0, w_addr}, 32'd7);
    chk("sb7_b_data", w_data, 32'h12345678);
    chk("sb7_clear", {31'd0, q_busy1}, 32'd0);
    tick();
    chk("sb7_once", {31'd0, w_en}, 32'd0);

    // FIFO fill, back-pressure and ordered drain
    a_valid = 1; a_addr = 5'd2; a_data = 32'h22;
    b_valid = 1; b_addr = 5'd10; b_data = 32'hA0;
    tick();
    chk("fill1_ready", {31'd0, b_ready}, 32'd1);
    b_addr = 5'd11; b_data = 32'hB0;
    tick();
    chk("fill2_ready", {31'd0, b_ready}, 32'd0);
    b_addr = 5'd12; b_data = 32'hC0;
    tick();
    chk("full_hold_ready", {31'd0, b_ready}, 32'd0);
    chk("full_a_addr", {27'd0, w_addr}, 32'd2);
    a_valid = 0;
    tick();
    chk("drain1_addr", {27'd0, w_addr}, 32'd10);
    chk("drain1_data", w_data, 32'hA0);
    chk("drain1_ready", {31'd0, b_ready}, 32'd1);
    tick();
    b_valid = 0;
    chk("drain2_addr", {27'd0, w_addr}, 32'd11);
    chk("drain2_data", w_data, 32'hB0);
    tick();
    chk("drain3_wen", {31'd0, w_en}, 32'd1);
    chk("drain3_addr", {27'd0, w_addr}, 32'd12);
    chk("drain3_data", w_data, 32'hC0);
    tick();
    chk("drain_done", {31'd0, w_en}, 32'd0);

    // set wins over clear on the same register
    iss_valid = 1; iss_addr = 5'd3;
    tick();
    iss_valid = 0;
    chk("sb3_set", {31'd0, q_busy2}, 32'd1);
    a_valid = 1; a_addr = 5'd1; a_data = 32'h1;
    b_valid = 1; b_addr = 5'd3; b_data = 32'h30;
    tick();
    a_valid = 0; b_valid = 0;
    iss_valid = 1; iss_addr = 5'd3;
    tick();
    iss_valid = 0;
    chk("sb3_b_addr", {27'd0, w_addr}, 32'd3);
    chk("sb3_setwins", {31'd0, q_busy2}, 32'd1);

    // single B latency from an idle, empty state
    b_valid = 1; b_addr = 5'd3; b_data = 32'h33;
    tick();
    b_valid = 0;
`ifdef OTTER_WB_BYPASS_EN
    chk("lat_n1_wen", {31'd0, w_en}, 32'd1);
    chk("lat_n1_data", w_data, 32'h33);
    chk("lat_sb3_clr", {31'd0, q_busy2}, 32'd0);
    tick();
    chk("lat_n2_wen", {31'd0, w_en}, 32'd0);
`else
    chk("lat_n1_wen", {31'd0, w_en}, 32'd0);
    tick();
    chk("lat_n2_wen", {31'd0, w_en}, 32'd1);
    chk("lat_n2_data", w_data, 32'h33);
    chk("lat_sb3_clr", {31'd0, q_busy2}, 32'd0);
`endif

    // x0 head popped silently, A to x0 does not block, then mid-stream reset
    iss_valid = 1; iss_addr = 5'd9; q_addr1 = 5'd9;
    a_valid = 1; a_addr = 5'd4; a_data = 32'h44;
    b_valid = 1; b_addr = 5'd0; b_data = 32'h5;
    tick();
    iss_valid = 0;
    b_addr = 5'd9; b_data = 32'h99;
    tick();
    b_valid = 0;
    chk("sb9_set", {31'd0, q_busy1}, 32'd1);
    a_addr = 5'd0;
    tick();
    chk("x0_head_wen", {31'd0, w_en}, 32'd0);
    chk("x0_head_ready", {31'd0, b_ready}, 32'd1);
    a_valid = 0;
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_wen", {31'd0, w_en}, 32'd0);
    chk("mrst_addr", {27'd0, w_addr}, 32'd0);
    chk("mrst_data", w_data, 32'd0);
    chk("mrst_ready", {31'd0, b_ready}, 32'd1);
    chk("mrst_sb9", {31'd0, q_busy1}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_wen1", {31'd0, w_en}, 32'd0);
    tick();
    chk("post_rst_wen2", {31'd0, w_en}, 32'd0);
    chk("post_rst_sb9", {31'd0, q_busy1}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
